// File: rtl/gpio_stream_rx.sv
// gpio_stream_rx: deserialises the GPIO (data) / GPIOBoolean (strobe) bit stream LSB-first
// into WORD_W-bit words buffered in a first-word-fall-through FIFO.
// Optional macro GPIO_RX_PARITY_EN adds a trailing even-parity bit per word.
module gpio_stream_rx #(
    parameter int WORD_W  = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       gpio_bit,
    input  logic                       gpio_valid,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [WORD_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       timeout_err,
    output logic                       parity_err
);
`ifdef GPIO_RX_PARITY_EN
    localparam int FRAME = WORD_W + 1;
`else
    localparam int FRAME = WORD_W;
`endif
    localparam int BC_W  = $clog2(FRAME + 1);
    localparam int IC_W  = $clog2(TIMEOUT + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

`ifdef GPIO_RX_PARITY_EN
    function automatic logic even_parity(input logic [WORD_W-1:0] data);
        return ^data;
    endfunction
`endif

    state_t            state_r, state_s;
    logic [WORD_W-1:0] shift_r, word_s, head_s, rd_data_r;
    logic [BC_W-1:0]   bitcnt_r;
    logic [IC_W-1:0]   idle_r;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [WORD_W-1:0] mem_r [DEPTH];
    logic              last_bit_s, parity_ok_s, timeout_s;
    logic              push_s, pop_s, drop_s, parity_fail_s;
    logic              empty_r, full_r, overflow_r, timeout_err_r, parity_err_r;

`ifdef GPIO_RX_PARITY_EN
    assign parity_ok_s = (even_parity(shift_r) == gpio_bit);
`else
    assign parity_ok_s = 1'b1;
`endif

    // Current word with this cycle's strobed bit merged in at position bitcnt_r
    always_comb begin
        word_s = shift_r;
        for (int i = 0; i < WORD_W; i++) begin
            if (gpio_valid && (bitcnt_r == BC_W'(i))) begin
                word_s[i] = gpio_bit;
            end else begin
                word_s[i] = shift_r[i];
            end
        end
    end

    // FSM next state; a strobe on the terminal idle count wins over the timeout
    always_comb begin
        state_s    = state_r;
        last_bit_s = gpio_valid && (bitcnt_r == BC_W'(FRAME - 1));
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (gpio_valid && !last_bit_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_s = IDLE;
                end else if (!gpio_valid && (idle_r == IC_W'(TIMEOUT - 1))) begin
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FIFO control and next registered head (may be the word being written)
    always_comb begin
        pop_s         = rd_en && !empty_r;
        push_s        = last_bit_s && parity_ok_s && (!full_r || pop_s);
        drop_s        = last_bit_s && parity_ok_s && full_r && !pop_s;
        parity_fail_s = last_bit_s && !parity_ok_s;
        rd_ptr_s      = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        if (push_s && !pop_s) begin
            count_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_s = count_r - CNT_W'(1);
        end else begin
            count_s = count_r;
        end
        if (count_s == {CNT_W{1'b0}}) begin
            head_s = {WORD_W{1'b0}};
        end else if (push_s && (rd_ptr_s == wr_ptr_r)) begin
            head_s = word_s;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Receiver state: FSM, shift register, bit and idle counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            shift_r  <= {WORD_W{1'b0}};
            bitcnt_r <= {BC_W{1'b0}};
            idle_r   <= {IC_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (last_bit_s || timeout_s) begin
                shift_r  <= {WORD_W{1'b0}};
                bitcnt_r <= {BC_W{1'b0}};
            end else if (gpio_valid) begin
                shift_r  <= word_s;
                bitcnt_r <= bitcnt_r + BC_W'(1);
            end else begin
                shift_r  <= shift_r;
                bitcnt_r <= bitcnt_r;
            end
            if ((state_r == SHIFT) && !gpio_valid && !timeout_s) begin
                idle_r <= idle_r + IC_W'(1);
            end else begin
                idle_r <= {IC_W{1'b0}};
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // FIFO pointers, count, status and registered head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            rd_data_r <= {WORD_W{1'b0}};
        end else begin
            wr_ptr_r  <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
            rd_ptr_r  <= rd_ptr_s;
            count_r   <= count_s;
            empty_r   <= (count_s == {CNT_W{1'b0}});
            full_r    <= (count_s == CNT_W'(DEPTH));
            rd_data_r <= head_s;
        end
    end

    // Sticky error flags; a new event beats clr_err
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            parity_err_r  <= 1'b0;
        end else begin
            overflow_r    <= drop_s | (overflow_r & ~clr_err);
            timeout_err_r <= timeout_s | (timeout_err_r & ~clr_err);
            parity_err_r  <= parity_fail_s | (parity_err_r & ~clr_err);
        end
    end

    assign rd_data     = rd_data_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign count       = count_r;
    assign overflow    = overflow_r;
    assign timeout_err = timeout_err_r;
    assign parity_err  = parity_err_r;
endmodule

// File: tb/tb_gpio_stream_rx.sv
// Self-checking bench for gpio_stream_rx: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_gpio_stream_rx;
    localparam int WORD_W  = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
`ifdef GPIO_RX_PARITY_EN
    localparam int FRAME = WORD_W + 1;
`else
    localparam int FRAME = WORD_W;
`endif

    logic              clk = 1'b0;
    logic              reset, gpio_bit, gpio_valid, rd_en, clr_err;
    logic [WORD_W-1:0] rd_data;
    logic              empty, full, overflow, timeout_err, parity_err;
    logic [3:0]        count;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [WORD_W-1:0] mq[$];
    bit                bits[$];
    int                gap;
    bit                m_ovf, m_tmo, m_par;

    gpio_stream_rx #(.WORD_W(WORD_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .gpio_bit(gpio_bit), .gpio_valid(gpio_valid),
        .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .empty(empty),
        .full(full), .count(count), .overflow(overflow),
        .timeout_err(timeout_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        mq.delete();
        bits.delete();
        gap   = 0;
        m_ovf = 1'b0;
        m_tmo = 1'b0;
        m_par = 1'b0;
    endfunction

    function automatic logic [WORD_W:0] frame_of(input logic [WORD_W-1:0] w, input bit flip);
        return {(^w) ^ flip, w};
    endfunction

    // drive one cycle, advance the model, return #1 after the edge
    task automatic step(input logic v, input logic b, input logic r, input logic c);
        logic [WORD_W-1:0] w;
        bit done, pfail, tev, oev, pop;
        gpio_valid = v; gpio_bit = b; rd_en = r; clr_err = c;
        @(posedge clk);
        done = 0; pfail = 0; tev = 0; oev = 0; w = '0;
        pop = r && (mq.size() > 0);
        if (v) begin
            bits.push_back(b);
            gap = 0;
            if (bits.size() == FRAME) begin
                for (int i = 0; i < WORD_W; i++) w[i] = bits[i];
`ifdef GPIO_RX_PARITY_EN
                pfail = ((^w) != bits[WORD_W]);
`endif
                done = !pfail;
                bits.delete();
            end
        end else if (bits.size() > 0) begin
            gap++;
            if (gap >= TIMEOUT) begin
                bits.delete();
                gap = 0;
                tev = 1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (done) begin
            if (mq.size() >= DEPTH) oev = 1;
            else mq.push_back(w);
        end
        m_ovf = oev   | (m_ovf & !c);
        m_tmo = tev   | (m_tmo & !c);
        m_par = pfail | (m_par & !c);
        #1;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input bit rd_last, input bit flip);
        logic [WORD_W:0] fr;
        fr = frame_of(w, flip);
        for (int i = 0; i < FRAME; i++) step(1'b1, fr[i], rd_last && (i == FRAME - 1), 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        total++; if ({overflow, timeout_err, parity_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {overflow, timeout_err, parity_err});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        send_word(8'hA5, 1'b0, 1'b0);
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0b exp=0", empty); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL basic_rd_data got=%h exp=a5", rd_data); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_pop_empty got=%0b exp=1", empty); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL basic_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 9; k++) send_word(8'(k), 1'b0, 1'b0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0b exp=1", full); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        for (int k = 1; k <= 8; k++) begin
            total++; if (rd_data !== 8'(k)) begin bad++; $display("FAIL ovf_order got=%h exp=%h", rd_data, 8'(k)); end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_drained got=%0b exp=1", empty); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
    endtask

    task automatic test_push_pop_full();
        for (int k = 0; k < 8; k++) send_word(8'(8'h10 + k), 1'b0, 1'b0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL pp_full got=%0b exp=1", full); end
        send_word(8'h55, 1'b1, 1'b0);
        total++; if (count !== 4'd8) begin bad++; $display("FAIL pp_count got=%0d exp=8", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow got=%0b exp=0", overflow); end
        for (int k = 1; k < 8; k++) begin
            total++; if (rd_data !== 8'(8'h10 + k)) begin bad++; $display("FAIL pp_order got=%h exp=%h", rd_data, 8'(8'h10 + k)); end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        total++; if (rd_data !== 8'h55) begin bad++; $display("FAIL pp_last got=%h exp=55", rd_data); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL pp_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_timeout();
        logic [WORD_W:0] fr;
        // gap of TIMEOUT-1 idle cycles is tolerated
        fr = frame_of(8'h96, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, fr[i], 1'b0, 1'b0);
        repeat (TIMEOUT - 1) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < FRAME; i++) step(1'b1, fr[i], 1'b0, 1'b0);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_edge_flag got=%0b exp=0", timeout_err); end
        total++; if (rd_data !== 8'h96 || count !== 4'd1) begin
            bad++; $display("FAIL tmo_edge_word got=%h/%0d exp=96/1", rd_data, count);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        // gap of TIMEOUT idle cycles discards the partial word
        fr = frame_of(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, fr[i], 1'b0, 1'b0);
        repeat (TIMEOUT) step(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%0b exp=1", timeout_err); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL tmo_empty got=%0b exp=1", empty); end
        send_word(8'h3C, 1'b0, 1'b0);
        total++; if (rd_data !== 8'h3C || count !== 4'd1) begin
            bad++; $display("FAIL tmo_word got=%h/%0d exp=3c/1", rd_data, count);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%0b exp=0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        logic [WORD_W:0] fr;
        send_word(8'h11, 1'b0, 1'b0);
        fr = frame_of(8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, fr[i], 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        total++; if (empty !== 1'b1 || count !== 4'd0 || rd_data !== 8'h00) begin
            bad++; $display("FAIL rstmid_state got=%0b/%0d/%h exp=1/0/00", empty, count, rd_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        send_word(8'h7E, 1'b0, 1'b0);
        total++; if (rd_data !== 8'h7E || count !== 4'd1) begin
            bad++; $display("FAIL rstmid_word got=%h/%0d exp=7e/1", rd_data, count);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

`ifdef GPIO_RX_PARITY_EN
    task automatic test_parity();
        send_word(8'h0F, 1'b0, 1'b0);
        total++; if (rd_data !== 8'h0F || count !== 4'd1) begin
            bad++; $display("FAIL par_good got=%h/%0d exp=0f/1", rd_data, count);
        end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_good_flag got=%0b exp=0", parity_err); end
        send_word(8'h0F, 1'b0, 1'b1);
        total++; if (count !== 4'd1) begin bad++; $display("FAIL par_bad_count got=%0d exp=1", count); end
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_bad_flag got=%0b exp=1", parity_err); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_clear got=%0b exp=0", parity_err); end
    endtask
`endif

    task automatic test_random();
        int   burst, rdp, ph;
        logic v, r, c;
        burst = 0;
        for (int n = 0; n < 4500; n++) begin
            ph = (n / 500) % 3;
            if (burst == 0 && $urandom_range(0, 149) == 0) burst = int'($urandom_range(55, 75));
            if (burst > 0) begin
                v = 1'b0;
                burst--;
            end else begin
                v = ($urandom_range(0, 99) < 70);
            end
            rdp = (ph == 0) ? 30 : ((ph == 1) ? 2 : 60);
            r = ($urandom_range(0, 99) < rdp);
            c = ($urandom_range(0, 99) < 3);
            step(v, 1'($urandom_range(0, 1)), r, c);
            total++; if (count !== 4'(mq.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, mq.size()); end
            total++; if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty n=%0d got=%0b", n, empty); end
            total++; if (full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full n=%0d got=%0b", n, full); end
            total++; if ({overflow, timeout_err, parity_err} !== {m_ovf, m_tmo, m_par}) begin
                bad++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {overflow, timeout_err, parity_err}, {m_ovf, m_tmo, m_par});
            end
            if (mq.size() > 0) begin
                total++; if (rd_data !== mq[0]) begin bad++; $display("FAIL rnd_rd_data n=%0d got=%h exp=%h", n, rd_data, mq[0]); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; gpio_bit = 1'b0; gpio_valid = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_full();
        test_timeout();
        test_reset_mid();
`ifdef GPIO_RX_PARITY_EN
        test_parity();
`endif
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpio_stream_rx.md
Name: gpio_stream_rx

Overview:
- Receive-side endpoint for the processor's GPIO output pair: `GPIO` is the data bit and `GPIOBoolean` is the bit-valid strobe.
- Deserialises the bit stream LSB-first into WORD_W-bit words and buffers them in a DEPTH-entry FIFO.
- A consumer (display/UART bridge or test harness) drains the FIFO through a first-word-fall-through read port.
- Detects stalled partial words (timeout), FIFO overflow and, optionally, parity errors.

Parameters:
- WORD_W, 8, bits per received word
- DEPTH, 8, FIFO entries; power of two, at least 2
- TIMEOUT, 64, idle clk cycles allowed between bits inside a word before the partial word is discarded

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- gpio_bit  in  1  serial data bit, driven from processor GPIO
- gpio_valid  in  1  bit strobe, driven from processor GPIOBoolean; each high cycle carries one bit
- rd_en  in  1  pop the head word; ignored while empty
- clr_err  in  1  synchronous clear of all sticky error flags
- rd_data  out  WORD_W  head of FIFO; valid while empty=0
- empty  out  1  FIFO holds no words
- full  out  1  FIFO holds DEPTH words
- count  out  $clog2(DEPTH+1)  number of stored words
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full
- timeout_err  out  1  sticky: a partial word was discarded by timeout
- parity_err  out  1  sticky: parity mismatch; constant 0 when GPIO_RX_PARITY_EN is undefined

Behaviour:
- Reset state:
  - FSM in IDLE; shift register, bit counter, idle counter, FIFO pointers and count cleared.
  - rd_data=0, empty=1, full=0, count=0, overflow=0, timeout_err=0, parity_err=0.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on the first gpio_valid: bit stored at position 0, bit counter=1.
  - In SHIFT, each gpio_valid shifts gpio_bit into position `bitcnt`, so words are LSB-first.
  - The word completes on the gpio_valid that makes `bitcnt`=WORD_W. That cycle the word is pushed and the FSM returns to IDLE.
  - Back-to-back words are allowed: a gpio_valid in the cycle after completion starts the next word.
- Idle counter:
  - Runs only in SHIFT and resets on every gpio_valid.
  - When it reaches TIMEOUT with no strobe, the partial word is discarded, timeout_err is set and the FSM goes to IDLE.
  - If a gpio_valid coincides with the terminal count, the bit is accepted and no timeout occurs.
- Latency:
  - A word completed at edge N appears on rd_data, with empty=0, after edge N.
  - It is readable in the cycle following N.
- FIFO:
  - First-word fall-through; rd_data is the registered head entry.
  - rd_en with empty=0 pops at the edge; rd_en with empty=1 is a no-op.
- Push and pop:
  - Push with pop in the same cycle: both occur and count is unchanged. This holds even when full, because the pop frees the slot.
  - Push when full with no pop: the word is dropped, overflow is set, FIFO contents are unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- full=(count==DEPTH) and empty=(count==0), both derived from the registered count.
- Sticky flags:
  - Cleared only by reset or clr_err.
  - If clr_err coincides with a new error event, the flag is set, since set has priority.
- Reset mid-word or mid-read: all state is cleared immediately (asynchronous); partial and buffered words are lost.

Optional Feature:
- Macro GPIO_RX_PARITY_EN.
- Defined:
  - Each word is followed by one extra strobed bit carrying even parity over the WORD_W data bits.
  - The word completes on that (WORD_W+1)th strobe.
  - On mismatch the word is not pushed and parity_err is set.
  - The timeout also covers the gap before the parity bit.
- Undefined: words are WORD_W bits with no parity bit, and parity_err is tied to 0.

Test Plan:
- Send 8 strobed bits for 0xA5 LSB-first (1,0,1,0,0,1,0,1) -> after the 8th edge: empty=0, rd_data=0xA5, count=1; pulse rd_en -> empty=1, count=0.
- Send 9 back-to-back words 0x01..0x09 with DEPTH=8 and no reads -> full=1, count=8, overflow=1; reads return 0x01..0x08 in order.
- With the FIFO full, complete a word in the same cycle as rd_en -> count stays 8, overflow stays 0, the new word is last out.
- Send 3 bits, idle 64 cycles, then send a full word 0x3C -> timeout_err=1 and only 0x3C is stored; clr_err -> timeout_err=0.
- Assert reset for 1 cycle after 5 bits, then send a full word 0x7E -> outputs return to reset values, then only 0x7E is stored.
- GPIO_RX_PARITY_EN: send 0x0F with parity bit 0 -> stored; send 0x0F with parity bit 1 -> not stored, parity_err=1.
